// File: rtl/airlock_pkg.sv
// Shared types for the bathysphere airlock chamber sequencer: FSM states and chamber level encoding.
package airlock_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    FILL  = 2'd1,
    DRAIN = 2'd2,
    WAIT  = 2'd3
  } state_e;

  localparam logic LVL_EMPTY = 1'b0;
  localparam logic LVL_FULL  = 1'b1;

  // Zero-length phases are stretched to a single tick.
  function automatic int eff_ticks(input int n);
    return (n == 0) ? 1 : n;
  endfunction

endpackage

// File: rtl/tick_prescaler.sv
// Divides the system clock into one-cycle tick pulses every CLK_PER_TICK enabled cycles.
module tick_prescaler #(
  parameter int CLK_PER_TICK = 50000000
) (
  input  logic clk,
  input  logic reset,
  input  logic clr,
  input  logic enable,
  output logic tick
);

  localparam int PW = (CLK_PER_TICK > 1) ? $clog2(CLK_PER_TICK) : 1;
  localparam logic [PW-1:0] LAST = PW'(CLK_PER_TICK - 1);

  logic [PW-1:0] cnt_q, cnt_d;

  assign tick = enable && (cnt_q == LAST);

  always_comb begin
    cnt_d = cnt_q;
    if (clr) begin
      cnt_d = '0;
    end else if (enable) begin
      cnt_d = tick ? '0 : cnt_q + PW'(1);
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) cnt_q <= '0;
    else       cnt_q <= cnt_d;
  end

endmodule

// File: rtl/airlock_chamber_seq.sv
// Airlock chamber sequencer: timed fill/drain/wait phases with door/pressure interlock.
// Optional `AIRLOCK_REMAIN_EN adds the remain_ticks output exposing the live tick counter.
module airlock_chamber_seq
  import airlock_pkg::*;
#(
  parameter int CLK_PER_TICK = 50000000,
  parameter int FILL_TICKS   = 7,
  parameter int DRAIN_TICKS  = 8,
  parameter int WAIT_TICKS   = 5,
  parameter int CNT_W        = 4
) (
  input  logic clk,
  input  logic reset,
  input  logic fill_req,
  input  logic drain_req,
  input  logic wait_req,
  input  logic inner_door_cmd,
  input  logic outer_door_cmd,
  output logic filling,
  output logic draining,
  output logic waiting,
  output logic inner_door_open,
  output logic outer_door_open,
  output logic chamber_full,
  output logic fill_done,
  output logic drain_done,
  output logic wait_done,
  output logic req_err
`ifdef AIRLOCK_REMAIN_EN
  ,
  output logic [CNT_W-1:0] remain_ticks
`endif
);

  localparam logic [CNT_W-1:0] FILL_LD  = CNT_W'(eff_ticks(FILL_TICKS));
  localparam logic [CNT_W-1:0] DRAIN_LD = CNT_W'(eff_ticks(DRAIN_TICKS));
  localparam logic [CNT_W-1:0] WAIT_LD  = CNT_W'(eff_ticks(WAIT_TICKS));

  state_e           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             full_q, full_d;
  logic             inner_q, inner_d;
  logic             outer_q, outer_d;
  logic             fill_done_q, fill_done_d;
  logic             drain_done_q, drain_done_d;
  logic             wait_done_q, wait_done_d;
  logic             err_q, err_d;
  logic             tick;
  logic             accept;
  logic             idle;
  logic             doors_closed;

  assign idle         = (state_q == IDLE);
  assign doors_closed = !inner_q && !outer_q;

  tick_prescaler #(
    .CLK_PER_TICK(CLK_PER_TICK)
  ) u_prescaler (
    .clk   (clk),
    .reset (reset),
    .clr   (accept),
    .enable(!idle),
    .tick  (tick)
  );

  always_comb begin
    state_d      = state_q;
    cnt_d        = cnt_q;
    full_d       = full_q;
    fill_done_d  = 1'b0;
    drain_done_d = 1'b0;
    wait_done_d  = 1'b0;
    err_d        = 1'b0;
    accept       = 1'b0;

    // Phase countdown; the last tick returns to IDLE and settles the chamber level.
    if (!idle && tick) begin
      if (cnt_q <= CNT_W'(1)) begin
        state_d = IDLE;
        cnt_d   = '0;
        case (state_q)
          FILL:    begin fill_done_d  = 1'b1; full_d = LVL_FULL;  end
          DRAIN:   begin drain_done_d = 1'b1; full_d = LVL_EMPTY; end
          WAIT:    wait_done_d = 1'b1;
          default: ;
        endcase
      end else begin
        cnt_d = cnt_q - CNT_W'(1);
      end
    end

    // Only the highest-priority request is judged; lower ones are dropped silently.
    if (drain_req || fill_req || wait_req) begin
      if (!idle || !doors_closed) begin
        err_d = 1'b1;
      end else if (drain_req) begin
        if (full_q == LVL_FULL) begin
          accept  = 1'b1;
          state_d = DRAIN;
          cnt_d   = DRAIN_LD;
        end else begin
          err_d = 1'b1;
        end
      end else if (fill_req) begin
        if (full_q == LVL_EMPTY) begin
          accept  = 1'b1;
          state_d = FILL;
          cnt_d   = FILL_LD;
        end else begin
          err_d = 1'b1;
        end
      end else begin
        accept  = 1'b1;
        state_d = WAIT;
        cnt_d   = WAIT_LD;
      end
    end

    // Doors may only open from a settled IDLE with no phase starting on the same edge.
    inner_d = inner_q ? inner_door_cmd
                      : (idle && !accept && full_q == LVL_EMPTY && !outer_q &&
                         inner_door_cmd && !outer_door_cmd);
    outer_d = outer_q ? outer_door_cmd
                      : (idle && !accept && full_q == LVL_FULL && !inner_q &&
                         outer_door_cmd && !inner_door_cmd);
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q      <= IDLE;
      cnt_q        <= '0;
      full_q       <= LVL_EMPTY;
      inner_q      <= 1'b0;
      outer_q      <= 1'b0;
      fill_done_q  <= 1'b0;
      drain_done_q <= 1'b0;
      wait_done_q  <= 1'b0;
      err_q        <= 1'b0;
    end else begin
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      full_q       <= full_d;
      inner_q      <= inner_d;
      outer_q      <= outer_d;
      fill_done_q  <= fill_done_d;
      drain_done_q <= drain_done_d;
      wait_done_q  <= wait_done_d;
      err_q        <= err_d;
    end
  end

  assign filling         = (state_q == FILL);
  assign draining        = (state_q == DRAIN);
  assign waiting         = (state_q == WAIT);
  assign inner_door_open = inner_q;
  assign outer_door_open = outer_q;
  assign chamber_full    = full_q;
  assign fill_done       = fill_done_q;
  assign drain_done      = drain_done_q;
  assign wait_done       = wait_done_q;
  assign req_err         = err_q;

`ifdef AIRLOCK_REMAIN_EN
  assign remain_ticks = cnt_q;
`endif

endmodule

// File: tb/tb_airlock_chamber_seq.sv
// Scoreboard bench for airlock_chamber_seq: a cycle-count reference model queues expected outputs,
// a monitor pops and compares them every cycle.
module tb_airlock_chamber_seq;

  localparam int CPT = 4;
  localparam int FT  = 3;
  localparam int DT  = 2;
  localparam int WT  = 1;
  localparam int CW  = 4;

  logic clk = 1'b0;
  logic reset = 1'b1;
  logic fill_req = 1'b0, drain_req = 1'b0, wait_req = 1'b0;
  logic inner_door_cmd = 1'b0, outer_door_cmd = 1'b0;
  logic filling, draining, waiting, inner_door_open, outer_door_open, chamber_full;
  logic fill_done, drain_done, wait_done, req_err;
  logic [CW-1:0] remainAct;

  always #5 clk = ~clk;

  airlock_chamber_seq #(
    .CLK_PER_TICK(CPT), .FILL_TICKS(FT), .DRAIN_TICKS(DT), .WAIT_TICKS(WT), .CNT_W(CW)
  ) dut (
    .clk(clk), .reset(reset),
    .fill_req(fill_req), .drain_req(drain_req), .wait_req(wait_req),
    .inner_door_cmd(inner_door_cmd), .outer_door_cmd(outer_door_cmd),
    .filling(filling), .draining(draining), .waiting(waiting),
    .inner_door_open(inner_door_open), .outer_door_open(outer_door_open),
    .chamber_full(chamber_full),
    .fill_done(fill_done), .drain_done(drain_done), .wait_done(wait_done),
    .req_err(req_err)
`ifdef AIRLOCK_REMAIN_EN
    , .remain_ticks(remainAct)
`endif
  );

`ifndef AIRLOCK_REMAIN_EN
  assign remainAct = '0;
`endif

  logic [9:0] actFlags;
  assign actFlags = {filling, draining, waiting, inner_door_open, outer_door_open, chamber_full,
                     fill_done, drain_done, wait_done, req_err};

  typedef struct packed {
    logic [9:0]    flags;
    logic [CW-1:0] remain;
    int            cyc;
  } exp_t;

  exp_t expQ[$];
  int   compared = 0;
  int   mismatched = 0;
  int   cycleNo = 0;

  // Reference model: phase tracked as cycles left (0 phase = idle, 1 fill, 2 drain, 3 wait).
  int   mPhase = 0;
  int   mLeft = 0;
  logic mFull = 0, mInner = 0, mOuter = 0;
  logic mFillDone = 0, mDrainDone = 0, mWaitDone = 0, mErr = 0;

  function automatic int phaseCycles(input int p);
    int n;
    n = (p == 1) ? FT : (p == 2) ? DT : WT;
    if (n == 0) n = 1;
    return n * CPT;
  endfunction

  function automatic exp_t modelOut();
    exp_t e;
    e.flags  = {mPhase == 1, mPhase == 2, mPhase == 3, mInner, mOuter, mFull,
                mFillDone, mDrainDone, mWaitDone, mErr};
    e.remain = (mPhase == 0) ? '0 : CW'((mLeft + CPT - 1) / CPT);
    e.cyc    = cycleNo;
    return e;
  endfunction

  task automatic modelStep(input logic r, f, d, w, ic, oc);
    int   sel;
    logic idleNow, acc, innerN, outerN;
    if (r) begin
      mPhase = 0; mLeft = 0; mFull = 0; mInner = 0; mOuter = 0;
      mFillDone = 0; mDrainDone = 0; mWaitDone = 0; mErr = 0;
      return;
    end
    idleNow = (mPhase == 0);
    acc = 0;
    mFillDone = 0; mDrainDone = 0; mWaitDone = 0; mErr = 0;
    sel = d ? 2 : f ? 1 : w ? 3 : 0;
    if (sel != 0) begin
      if (!idleNow || mInner || mOuter) mErr = 1;
      else if (sel == 1 && mFull)       mErr = 1;
      else if (sel == 2 && !mFull)      mErr = 1;
      else                              acc = 1;
    end
    innerN = mInner ? ic : (idleNow && !acc && !mFull && !mOuter && ic && !oc);
    outerN = mOuter ? oc : (idleNow && !acc && mFull && !mInner && oc && !ic);
    if (!idleNow) begin
      mLeft--;
      if (mLeft == 0) begin
        case (mPhase)
          1: begin mFillDone = 1; mFull = 1; end
          2: begin mDrainDone = 1; mFull = 0; end
          default: mWaitDone = 1;
        endcase
        mPhase = 0;
      end
    end
    if (acc) begin
      mPhase = sel;
      mLeft  = phaseCycles(sel);
    end
    mInner = innerN;
    mOuter = outerN;
  endtask

  task automatic checkOutput(input string name, input int cyc, input logic [31:0] got,
                             input logic [31:0] want);
    compared++;
    if (got !== want) begin
      mismatched++;
      $display("[TB] FAIL %s cycle %0d: got %b want %b", name, cyc, got, want);
    end
  endtask

  // One stimulus cycle: drive inputs after the falling edge, advance the model, queue expectation.
  task automatic applyStimulus(input logic r, f, d, w, ic, oc);
    @(negedge clk);
    #1;
    reset = r; fill_req = f; drain_req = d; wait_req = w;
    inner_door_cmd = ic; outer_door_cmd = oc;
    cycleNo++;
    modelStep(r, f, d, w, ic, oc);
    expQ.push_back(modelOut());
    if (r) begin
      #1;
      checkOutput("resetNow", cycleNo, 32'(actFlags), 32'(0));
    end
  endtask

  task automatic idleCycles(input int n, input logic ic, input logic oc);
    for (int i = 0; i < n; i++) applyStimulus(0, 0, 0, 0, ic, oc);
  endtask

  initial begin : monitor
    exp_t e;
    forever begin
      @(negedge clk);
      if (expQ.size() > 0) begin
        e = expQ.pop_front();
        checkOutput("outputs", e.cyc, 32'(actFlags), 32'(e.flags));
`ifdef AIRLOCK_REMAIN_EN
        checkOutput("remainTicks", e.cyc, 32'(remainAct), 32'(e.remain));
`endif
      end
    end
  end

  initial begin : stimulus
    logic ic, oc;
    applyStimulus(1, 0, 0, 0, 0, 0);
    applyStimulus(1, 0, 0, 0, 0, 0);
    idleCycles(2, 0, 0);

    // Drain while empty, then a fill with a re-request in the middle of it.
    applyStimulus(0, 0, 1, 0, 0, 0);
    idleCycles(2, 0, 0);
    applyStimulus(0, 1, 0, 0, 0, 0);
    idleCycles(3, 0, 0);
    applyStimulus(0, 1, 0, 0, 0, 0);
    idleCycles(12, 0, 0);

    // Doors while full: outer opens, wait/fill rejected, inner command ignored.
    idleCycles(3, 0, 1);
    applyStimulus(0, 0, 0, 1, 0, 1);
    applyStimulus(0, 1, 0, 0, 0, 1);
    idleCycles(2, 0, 0);
    idleCycles(3, 1, 0);
    idleCycles(2, 1, 1);
    idleCycles(1, 0, 0);

    // All three requests while full: drain wins with no error.
    applyStimulus(0, 1, 1, 1, 0, 0);
    idleCycles(10, 0, 0);
    idleCycles(3, 1, 0);
    idleCycles(2, 0, 0);

    // Back-to-back wait phases with a held request.
    for (int i = 0; i < 12; i++) applyStimulus(0, 0, 0, 1, 0, 0);
    idleCycles(2, 0, 0);

    // Reset in the middle of a fill, then a complete fill afterwards.
    applyStimulus(0, 1, 0, 0, 0, 0);
    idleCycles(4, 0, 0);
    applyStimulus(1, 0, 0, 0, 0, 0);
    applyStimulus(1, 0, 0, 0, 0, 0);
    applyStimulus(0, 1, 0, 0, 0, 0);
    idleCycles(14, 0, 0);

    // Randomised traffic: door commands held for stretches, sparse requests, rare resets.
    ic = 0; oc = 0;
    for (int i = 0; i < 3000; i++) begin
      if ($urandom_range(15) == 0) ic = ~ic;
      if ($urandom_range(15) == 0) oc = ~oc;
      applyStimulus(($urandom_range(499) == 0),
                    ($urandom_range(9) == 0), ($urandom_range(9) == 0),
                    ($urandom_range(11) == 0), ic, oc);
    end
    idleCycles(20, 0, 0);

    @(negedge clk);
    #2;
    checkOutput("queueDrained", cycleNo, 32'(expQ.size()), 32'(0));
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule

// File: doc/airlock_chamber_seq.md
Name: airlock_chamber_seq

Overview:
- Hardware chamber sequencer for the bathysphere airlock; sits directly downstream of the Nios microprocessor system.
- Consumes the processor's one-shot fill/drain/wait requests and door commands.
- Runs the timed fill/drain/wait phases, enforces the door/pressure interlock, and returns filling/draining/waiting/door status levels and done pulses to the processor PIOs.

Parameters:
- CLK_PER_TICK, 50000000, clock cycles per timing tick (1 s at 50 MHz); must be >=1
- FILL_TICKS, 7, ticks for a fill phase; 0 treated as 1
- DRAIN_TICKS, 8, ticks for a drain phase; 0 treated as 1
- WAIT_TICKS, 5, ticks for a wait phase; 0 treated as 1
- CNT_W, 4, width of tick counter; must hold max(FILL_TICKS, DRAIN_TICKS, WAIT_TICKS)

Ports:
- clk  in  1  system clock
- reset  in  1  asynchronous, active-high reset
- fill_req  in  1  request fill phase, sampled per cycle
- drain_req  in  1  request drain phase
- wait_req  in  1  request wait phase
- inner_door_cmd  in  1  level: 1 = request inner door open
- outer_door_cmd  in  1  level: 1 = request outer door open
- filling  out  1  high during fill phase
- draining  out  1  high during drain phase
- waiting  out  1  high during wait phase
- inner_door_open  out  1  inner door state
- outer_door_open  out  1  outer door state
- chamber_full  out  1  chamber level: 1 = FULL, 0 = EMPTY
- fill_done  out  1  one-cycle pulse at fill end
- drain_done  out  1  one-cycle pulse at drain end
- wait_done  out  1  one-cycle pulse at wait end
- req_err  out  1  one-cycle pulse on rejected request

Behaviour:
- Interface: one clock; reset is asynchronous and active-high.
- Reset state: FSM IDLE; prescaler and tick counter 0; chamber_full 0 (EMPTY); all outputs 0.
- FSM states: IDLE, FILL, DRAIN, WAIT.
- Request acceptance: only in IDLE with both doors closed.
  - fill_req accepted only if EMPTY.
  - drain_req accepted only if FULL.
  - wait_req accepted at either level.
- Simultaneous requests in one cycle: priority drain > fill > wait. Lower-priority requests are dropped silently, with no req_err.
- Rejected request: req_err pulses next cycle; state unchanged. Covers: busy, door open, fill when FULL, drain when EMPTY.
- Phase timing, on accepting a request at edge t:
  - state and phase output assert from cycle t+1.
  - prescaler cleared; tick counter loaded with N.
  - each tick (prescaler wrap at CLK_PER_TICK-1) decrements the counter.
  - phase output is high for exactly N*CLK_PER_TICK cycles.
- Phase end, in the first cycle the phase output is low:
  - FSM returns to IDLE.
  - matching done pulse is high for one cycle.
  - chamber_full updates in that same cycle: FILL sets 1, DRAIN clears 0, WAIT leaves it unchanged.
- A new request is accepted on the done-pulse cycle (back-to-back allowed).
- Doors, with 1-cycle registered latency:
  - outer door opens only if IDLE, FULL, inner door closed, and outer_door_cmd=1.
  - inner door opens only if IDLE, EMPTY, outer door closed, and inner_door_cmd=1.
  - a door closes the cycle after its cmd drops.
  - both cmds high with both doors closed: neither opens (no error).
  - an ignored door cmd does not pulse req_err.
- Invariants:
  - never both doors open.
  - no door is open outside IDLE.
  - at most one of filling/draining/waiting is high.
- Requests are pulses or levels; each cycle with req high is evaluated independently. A held request re-triggers after done only if the acceptance conditions hold.
- Reset mid-phase: immediate return to the reset state; chamber_full returns to EMPTY.

Optional Feature:
- Macro: AIRLOCK_REMAIN_EN.
- Defined: adds output port remain_ticks [CNT_W-1:0]. It equals the tick counter value during a phase (N at phase start, decrementing each tick) and 0 in IDLE.
- Undefined: no port; behaviour otherwise identical.

Decomposition:
- Package airlock_pkg:
  - state enum (IDLE, FILL, DRAIN, WAIT).
  - level constants LVL_EMPTY/LVL_FULL.
- Sub-module tick_prescaler:
  - inputs clr, enable; output tick pulse; parameter CLK_PER_TICK.
  - used once.

Test Plan (all cases use CLK_PER_TICK=4, FILL_TICKS=3, DRAIN_TICKS=2, WAIT_TICKS=1):
- Fill after reset: fill_req pulse -> filling high 12 cycles, then fill_done 1 cycle and chamber_full=1 the same cycle.
- Illegal requests:
  - drain_req while EMPTY -> req_err pulse, state IDLE.
  - fill_req during FILL -> req_err, phase length unchanged.
- Doors:
  - FULL, outer_door_cmd=1 -> outer_door_open next cycle.
  - fill_req while outer open -> req_err.
  - inner_door_cmd=1 while FULL -> inner stays 0.
- Simultaneous drain_req+fill_req+wait_req while FULL, doors closed -> draining 8 cycles, drain_done, chamber_full=0, no req_err.
- Reset asserted mid-FILL (cycle 5) -> all outputs 0 immediately, chamber_full=0; a fill_req after release completes in 12 cycles.
- With AIRLOCK_REMAIN_EN: remain_ticks reads 3,2,1 across FILL, then 0 in IDLE.
